// File: rtl/transposed_fir_sum_stage.sv
// Transposed-form FIR adder/delay chain. Takes a vector of per-tap products, accumulates
// through the z chain, rounds half-up, saturates to OUT_W and presents a one-entry
// valid/ready output register. Counts saturated outputs for debug.
module transposed_fir_sum_stage #(
  parameter int unsigned NTAPS  = 8,
  parameter int unsigned PROD_W = 27,
  parameter int unsigned ACC_W  = 30,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 10
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    clear,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NTAPS*PROD_W-1:0] s_prod,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUT_W-1:0]        m_data,
  output logic                    m_sat,
  output logic [15:0]             sat_count
);

  localparam int unsigned ZN = NTAPS - 1;

  // Half-LSB of the output grid, for round-half-up.
  localparam logic signed [ACC_W:0] Rnd =
      {{(ACC_W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [ACC_W:0] OutMax = (ACC_W + 1)'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] OutMin = ~OutMax;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                  state_q;
  logic [OUT_W-1:0]        data_q;
  logic                    sat_q;
  logic [15:0]             sat_count_q;
  logic signed [ACC_W-1:0] z_q [ZN];
  logic signed [ACC_W-1:0] z_d [ZN];
  logic signed [ACC_W-1:0] p_ext [NTAPS];
  logic signed [ACC_W-1:0] y;
  logic signed [ACC_W:0]   y_ext;
  logic signed [ACC_W:0]   y_rnd;
  logic signed [ACC_W:0]   r;
  logic [OUT_W-1:0]        data_d;
  logic                    sat_d;
  logic                    accept;

  assign m_valid   = (state_q == StFull);
  assign m_data    = data_q;
  assign m_sat     = sat_q;
  assign sat_count = sat_count_q;

  // Ready depends only on registered state, clear and reset; never on s_valid.
  assign s_ready = ap_rst_n && !clear && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  // Sign-extend products and form the next chain contents and the current sum.
  always_comb begin
    for (int unsigned k = 0; k < NTAPS; k++) begin
      p_ext[k] = {{(ACC_W - PROD_W){s_prod[k*PROD_W + PROD_W - 1]}},
                  s_prod[k*PROD_W +: PROD_W]};
    end
    for (int unsigned k = 0; k + 1 < ZN; k++) begin
      z_d[k] = p_ext[k+1] + z_q[k+1];
    end
    z_d[ZN-1] = p_ext[NTAPS-1];
    y         = p_ext[0] + z_q[0];
  end

  // Round half-up with one guard bit, then clamp to the signed output range.
  always_comb begin
    y_ext = {y[ACC_W-1], y};
    y_rnd = y_ext + Rnd;
    r     = y_rnd >>> SHIFT;
    if (r > OutMax) begin
      data_d = OutMax[OUT_W-1:0];
      sat_d  = 1'b1;
    end else if (r < OutMin) begin
      data_d = OutMin[OUT_W-1:0];
      sat_d  = 1'b1;
    end else begin
      data_d = r[OUT_W-1:0];
      sat_d  = 1'b0;
    end
  end

  // Delay chain: flushed by clear, advances only on an accepted beat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned k = 0; k < ZN; k++) z_q[k] <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < ZN; k++) z_q[k] <= '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < ZN; k++) z_q[k] <= z_d[k];
    end
  end

  // Output register state machine and sticky saturation counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StEmpty;
      data_q      <= '0;
      sat_q       <= 1'b0;
      sat_count_q <= '0;
    end else if (clear) begin
      state_q <= StEmpty;
    end else begin
      if (accept) begin
        state_q <= StFull;
        data_q  <= data_d;
        sat_q   <= sat_d;
        if (sat_d && (sat_count_q != 16'hFFFF)) begin
          sat_count_q <= sat_count_q + 16'd1;
        end
      end else if (m_ready) begin
        state_q <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_transposed_fir_sum_stage.sv
// Randomized and directed bench for transposed_fir_sum_stage against a direct-form
// convolution model over the history of accepted product vectors.
`timescale 1ns / 100ps
module tb_transposed_fir_sum_stage;

  localparam int NTAPS  = 8;
  localparam int PROD_W = 27;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 10;
  localparam int PW     = NTAPS * PROD_W;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             clear;
  logic             s_valid;
  logic             s_ready;
  logic [PW-1:0]    s_prod;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_sat;
  logic [15:0]      sat_count;

  transposed_fir_sum_stage #(
    .NTAPS (NTAPS),
    .PROD_W(PROD_W),
    .ACC_W (30),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clear    (clear),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_prod   (s_prod),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sat    (m_sat),
    .sat_count(sat_count)
  );

  initial forever #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // Model state: last NTAPS accepted vectors (hist[0] newest), pending output, counter.
  logic [PW-1:0] hist [NTAPS];
  longint        qd[$];
  bit            qs[$];
  longint        seen[$];
  int            exp_satcnt = 0;

  int            h_coef [NTAPS] = '{1024, 512, 256, 128, 64, 32, 16, 8};
  longint        imp_exp [9] = '{1000, 500, 250, 125, 63, 31, 16, 8, 0};

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint tap(input logic [PW-1:0] v, input int k);
    logic signed [PROD_W-1:0] t;
    t = v[k*PROD_W +: PROD_W];
    return longint'(t);
  endfunction

  function automatic logic [PW-1:0] mk_all(input longint val);
    logic [PW-1:0] v;
    for (int k = 0; k < NTAPS; k++) v[k*PROD_W +: PROD_W] = val[PROD_W-1:0];
    return v;
  endfunction

  function automatic logic [PW-1:0] mk_imp();
    logic [PW-1:0] v;
    longint        p;
    for (int k = 0; k < NTAPS; k++) begin
      p = 1000 * h_coef[k];
      v[k*PROD_W +: PROD_W] = p[PROD_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [PW-1:0] mk_rand();
    logic [PW-1:0]            v;
    logic signed [PROD_W-1:0] t;
    for (int k = 0; k < NTAPS; k++) begin
      t = PROD_W'($urandom);
      t = t >>> $urandom_range(0, 14);
      v[k*PROD_W +: PROD_W] = t;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) hist[k] = '0;
    qd.delete();
    qs.delete();
  endtask

  // One clock cycle: drive, sample at negedge against the model, advance the model.
  task automatic cycle(input bit v, input logic [PW-1:0] prod, input bit rdy, input bit clr,
                       output bit acc);
    bit     ev, er, s;
    longint y, r;
    s_valid = v;
    s_prod  = prod;
    m_ready = rdy;
    clear   = clr;
    @(negedge ap_clk);
    ev = (qd.size() != 0);
    er = !clr && (!ev || rdy);
    check_eq("m_valid", longint'(m_valid), longint'(ev));
    check_eq("s_ready", longint'(s_ready), longint'(er));
    check_eq("sat_count", longint'(sat_count), longint'(exp_satcnt));
    if (ev) begin
      check_eq("m_data", longint'($signed(m_data)), qd[0]);
      check_eq("m_sat", longint'(m_sat), longint'(qs[0]));
    end
    acc = v && er;
    if (clr) begin
      for (int k = 0; k < NTAPS; k++) hist[k] = '0;
      qd.delete();
      qs.delete();
    end else begin
      if (ev && rdy) begin
        seen.push_back(qd.pop_front());
        void'(qs.pop_front());
      end
      if (acc) begin
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = prod;
        y = 0;
        for (int k = 0; k < NTAPS; k++) y += tap(hist[k], k);
        r = (y + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        s = 1'b0;
        if (r > 32767) begin
          r = 32767;
          s = 1'b1;
        end else if (r < -32768) begin
          r = -32768;
          s = 1'b1;
        end
        qd.push_back(r);
        qs.push_back(s);
        if (s && exp_satcnt < 65535) exp_satcnt++;
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  // Present one beat until accepted, optionally with random bubbles and backpressure.
  task automatic send(input logic [PW-1:0] prod, input bit bubbles);
    bit acc, v, rdy;
    for (int i = 0; i < 64; i++) begin
      v   = bubbles ? bit'($urandom_range(0, 1)) : 1'b1;
      rdy = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(v, prod, rdy, 1'b0, acc);
      if (acc) return;
    end
    check_eq("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 16; i++) begin
      if (qd.size() == 0) return;
      cycle(1'b0, '0, 1'b1, 1'b0, acc);
    end
    check_eq("drain_timeout", longint'(qd.size()), 0);
  endtask

  task automatic check_impulse(input string tag);
    check_eq({tag, "_count"}, longint'(seen.size()), 9);
    for (int i = 0; i < 9 && i < seen.size(); i++) check_eq(tag, seen[i], imp_exp[i]);
  endtask

  initial begin
    bit acc;
    int sc;
    ap_rst_n = 1'b0;
    clear    = 1'b0;
    s_valid  = 1'b0;
    m_ready  = 1'b0;
    s_prod   = '0;
    model_reset();

    // Reset values while reset is held.
    @(negedge ap_clk);
    check_eq("rst_m_valid", longint'(m_valid), 0);
    check_eq("rst_m_data", longint'(m_data), 0);
    check_eq("rst_m_sat", longint'(m_sat), 0);
    check_eq("rst_sat_count", longint'(sat_count), 0);
    check_eq("rst_s_ready", longint'(s_ready), 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Impulse response with rounding.
    seen.delete();
    send(mk_imp(), 1'b0);
    for (int i = 0; i < 8; i++) send('0, 1'b0);
    drain();
    check_impulse("impulse");

    // Positive saturation: 8 beats then counter check.
    for (int i = 0; i < 8; i++) send(mk_all(longint'(32767) * 2047), 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("pos_sat_count", longint'(sat_count), 8);
    for (int i = 0; i < 8; i++) send('0, 1'b0);
    drain();

    // Negative saturation, then the -1.5 rounding case.
    for (int i = 0; i < 8; i++) send(mk_all(longint'(-32768) * 2047), 1'b0);
    for (int i = 0; i < 8; i++) send('0, 1'b0);
    drain();
    seen.delete();
    send(mk_all(0) | PW'(27'h7FFFA00), 1'b0);
    drain();
    check_eq("neg_round", seen[0], -1);

    // Backpressure: stall 3 cycles after the first output.
    seen.delete();
    send(mk_imp(), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, '0, 1'b0, 1'b0, acc);
      check_eq("stall_no_accept", longint'(acc), 0);
    end
    for (int i = 0; i < 8; i++) send('0, 1'b0);
    drain();
    check_impulse("backpressure");

    // Same sequence with random bubbles and backpressure.
    seen.delete();
    send(mk_imp(), 1'b1);
    for (int i = 0; i < 8; i++) send('0, 1'b1);
    drain();
    check_impulse("bubbles");

    // Clear mid-stream after three outputs.
    seen.delete();
    send(mk_imp(), 1'b0);
    send('0, 1'b0);
    send('0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    sc = exp_satcnt;
    cycle(1'b1, mk_imp(), 1'b1, 1'b1, acc);
    for (int i = 0; i < 8; i++) send('0, 1'b0);
    drain();
    check_eq("clear_count", longint'(seen.size()), 11);
    for (int i = 3; i < seen.size(); i++) check_eq("clear_zero", seen[i], 0);
    check_eq("clear_satcnt", longint'(sat_count), longint'(sc));

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), mk_rand(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 49) == 0), acc);
    end
    drain();

    // Asynchronous reset pulse between edges, mid-stream.
    send(mk_imp(), 1'b0);
    send(mk_all(longint'(32767) * 2047), 1'b0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_eq("arst_m_valid", longint'(m_valid), 0);
    check_eq("arst_m_data", longint'(m_data), 0);
    check_eq("arst_m_sat", longint'(m_sat), 0);
    check_eq("arst_sat_count", longint'(sat_count), 0);
    check_eq("arst_s_ready", longint'(s_ready), 0);
    #0.5;
    ap_rst_n = 1'b1;
    model_reset();
    exp_satcnt = 0;
    seen.delete();
    for (int i = 0; i < 8; i++) send('0, 1'b0);
    drain();
    check_eq("arst_count", longint'(seen.size()), 8);
    for (int i = 0; i < seen.size(); i++) check_eq("arst_zero", seen[i], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
